// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM ramp sequencer and its timebase.
package pwm_pkg;

  localparam int DEF_CLK_PER_US = 50;
  localparam int DEF_W          = 5;
  localparam int DEF_HOLD_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus unit counter mirroring the PWM counter; boundary marks the start of each PWM period.
module pwm_timebase #(
  parameter int CLK_PER_US = pwm_pkg::DEF_CLK_PER_US,
  parameter int W          = pwm_pkg::DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] period_i,
  output logic         boundary_o
);

  localparam int TBW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [TBW-1:0] tb_q;
  logic [W-1:0]   unit_q;
  logic           tick;
  logic           last_unit;

  assign tick = (tb_q == TBW'(CLK_PER_US - 1));
  // A shrinking period can leave the unit count above the new last unit, so wrap on >=.
  assign last_unit  = (period_i == '0) || (unit_q >= period_i - W'(1));
  assign boundary_o = tick && last_unit;

  always_ff @(posedge clk) begin
    if (rst) begin
      tb_q   <= '0;
      unit_q <= '0;
    end else begin
      tb_q <= tick ? '0 : tb_q + TBW'(1);
      if (tick) begin
        unit_q <= last_unit ? '0 : unit_q + W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer driving a PWM counter's period/duty/load strobe; updates land on period boundaries.
// Define PWM_RAMP_IRQ_EN to add the sticky done_irq output and its irq_clr input.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int CLK_PER_US = DEF_CLK_PER_US,
  parameter int W          = DEF_W,
  parameter int HOLD_W     = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W-1:0]      cmd_period,
  input  logic [W-1:0]      cmd_duty,
  input  logic [W-1:0]      cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              stop,
  output logic [W-1:0]      pwm_period,
  output logic [W-1:0]      pwm_duty,
  output logic              pwm_en,
`ifdef PWM_RAMP_IRQ_EN
  input  logic              irq_clr,
  output logic              done_irq,
`endif
  output logic              busy
);

  state_e              state_q, state_d;
  logic [W-1:0]        per_q, per_d, tgt_q, tgt_d, step_q, step_d;
  logic [W-1:0]        pwm_period_q, pwm_period_d, pwm_duty_q, pwm_duty_d;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_cnt_q, hold_cnt_d;
  logic                pwm_en_q, pwm_en_d;
  logic                boundary, accept;
  logic [W-1:0]        cmd_per_clamped, next_duty;
  logic [W:0]          delta;

  pwm_timebase #(
    .CLK_PER_US (CLK_PER_US),
    .W          (W)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .period_i   (pwm_period_q),
    .boundary_o (boundary)
  );

  assign cmd_ready       = !rst && !stop && (state_q != ST_RAMP);
  assign accept          = cmd_valid && cmd_ready;
  assign cmd_per_clamped = (cmd_period == '0) ? W'(1) : cmd_period;

  // Distance to target is formed one bit wider and compared before stepping, so no wrap is possible.
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
    delta     = '0;
    next_duty = tgt_q;
    if (pwm_duty_q < tgt_q) begin
      delta = {1'b0, tgt_q} - {1'b0, pwm_duty_q};
      if (step_q != '0 && delta > {1'b0, step_q}) next_duty = pwm_duty_q + step_q;
    end else if (pwm_duty_q > tgt_q) begin
      delta = {1'b0, pwm_duty_q} - {1'b0, tgt_q};
      if (step_q != '0 && delta > {1'b0, step_q}) next_duty = pwm_duty_q - step_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    per_d        = per_q;
    tgt_d        = tgt_q;
    step_d       = step_q;
    hold_d       = hold_q;
    hold_cnt_d   = hold_cnt_q;
    pwm_period_d = pwm_period_q;
    pwm_duty_d   = pwm_duty_q;
    pwm_en_d     = 1'b0;
    if (stop) begin
      pwm_duty_d = '0;
      pwm_en_d   = 1'b1;
      hold_cnt_d = '0;
      state_d    = ST_IDLE;
    end else if (accept) begin
      per_d      = cmd_per_clamped;
      tgt_d      = (cmd_duty > cmd_per_clamped) ? cmd_per_clamped : cmd_duty;
      step_d     = cmd_step;
      hold_d     = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
      hold_cnt_d = '0;
      state_d    = ST_RAMP;
    end else if (state_q == ST_RAMP && boundary) begin
      if (hold_cnt_q == hold_q - HOLD_W'(1)) begin
        // Always strobe here, even with duty already on target, so the new period gets loaded.
        hold_cnt_d   = '0;
        pwm_period_d = per_q;
        pwm_duty_d   = next_duty;
        pwm_en_d     = 1'b1;
        if (next_duty == tgt_q) state_d = ST_HOLD;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      per_q        <= W'(1);
      tgt_q        <= '0;
      step_q       <= '0;
      hold_q       <= HOLD_W'(1);
      hold_cnt_q   <= '0;
      pwm_period_q <= W'(1);
      pwm_duty_q   <= '0;
      // NOTE: held high through reset so the first cycle after release loads the reset values.
      pwm_en_q     <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      per_q        <= per_d;
      tgt_q        <= tgt_d;
      step_q       <= step_d;
      hold_q       <= hold_d;
      hold_cnt_q   <= hold_cnt_d;
      pwm_period_q <= pwm_period_d;
      pwm_duty_q   <= pwm_duty_d;
      pwm_en_q     <= pwm_en_d;
    end
  end

  assign pwm_period = pwm_period_q;
  assign pwm_duty   = pwm_duty_q;
  assign pwm_en     = pwm_en_q;
  assign busy       = (state_q == ST_RAMP);

`ifdef PWM_RAMP_IRQ_EN
  logic done_irq_q;
  logic irq_set;

  assign irq_set = (state_q == ST_RAMP) && (state_d == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst)          done_irq_q <= 1'b0;
    else if (irq_set) done_irq_q <= 1'b1;
    else if (irq_clr) done_irq_q <= 1'b0;
  end

  assign done_irq = done_irq_q;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: expected load strobes are queued at command time and popped on pwm_en.
module tb_pwm_ramp_ctrl;

  localparam int CLK = 5;
  localparam int W   = 5;
  localparam int HW  = 8;

  typedef struct {
    int period;
    int duty;
    int gap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          stop = 1'b0;
  logic [W-1:0]  cmd_period = '0, cmd_duty = '0, cmd_step = '0;
  logic [HW-1:0] cmd_hold = '0;
  logic          cmd_ready, pwm_en, busy;
  logic [W-1:0]  pwm_period, pwm_duty;
`ifdef PWM_RAMP_IRQ_EN
  logic          irq_clr = 1'b0;
  logic          done_irq;
`endif

  exp_t sb[$];
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, en_seen = 0, last_en_cyc = 0, cur_duty = 0;

  pwm_ramp_ctrl #(
    .CLK_PER_US (CLK),
    .W          (W),
    .HOLD_W     (HW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_period (cmd_period),
    .cmd_duty   (cmd_duty),
    .cmd_step   (cmd_step),
    .cmd_hold   (cmd_hold),
    .stop       (stop),
    .pwm_period (pwm_period),
    .pwm_duty   (pwm_duty),
    .pwm_en     (pwm_en),
`ifdef PWM_RAMP_IRQ_EN
    .irq_clr    (irq_clr),
    .done_irq   (done_irq),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference ramp: one strobe per step, at least one even when already on target.
  task automatic push_steps(input int per_raw, input int duty_raw, input int step, input int hold);
    int per, tgt, h, cur;
    bit first;
    per   = (per_raw == 0) ? 1 : per_raw;
    tgt   = (duty_raw > per) ? per : duty_raw;
    h     = (hold == 0) ? 1 : hold;
    cur   = cur_duty;
    first = 1'b1;
    do begin
      if (cur < tgt)      cur = (step == 0 || tgt - cur <= step) ? tgt : cur + step;
      else if (cur > tgt) cur = (step == 0 || cur - tgt <= step) ? tgt : cur - step;
      sb.push_back('{per, cur, first ? 0 : h * per * CLK});
      first = 1'b0;
    end while (cur != tgt);
    cur_duty = cur;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && pwm_en) begin
        if (sb.size() == 0) begin
          check("spurious_en", pwm_en, 1'b0);
        end else begin
          e = sb.pop_front();
          check("step_period", pwm_period, e.period);
          check("step_duty", pwm_duty, e.duty);
          if (e.gap != 0) check("step_gap", cyc - last_en_cyc, e.gap);
        end
        last_en_cyc = cyc;
        en_seen++;
      end
    end
  endtask

  task automatic send(input int per, input int duty, input int step, input int hold);
    int budget;
    @(posedge clk); #1;
    cmd_period = W'(per);
    cmd_duty   = W'(duty);
    cmd_step   = W'(step);
    cmd_hold   = HW'(hold);
    cmd_valid  = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!cmd_ready && budget < 100);
    check("cmd_ready", cmd_ready, 1'b1);
    push_steps(per, duty, step, hold);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk); #1;
    check("busy_in_ramp", busy, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 5000) begin
      @(negedge clk); #1;
      budget++;
    end
    check({tag, "_drained"}, sb.size(), 0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    int base, budget;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_duty", pwm_duty, 0);
    check("rst_period", pwm_period, 1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b0);
    sb.push_back('{1, 0, 0});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_en", pwm_en, 1'b1);
    @(negedge clk); #1;
    check("post_rst_en_low", pwm_en, 1'b0);
    check("post_rst_ready", cmd_ready, 1'b1);

    send(20, 10, 3, 2);
    wait_drain("ramp_up");
    check("up_duty", pwm_duty, 10);
    check("up_period", pwm_period, 20);
`ifdef PWM_RAMP_IRQ_EN
    check("irq_set", done_irq, 1'b1);
    repeat (5) @(negedge clk);
    check("irq_sticky", done_irq, 1'b1);
    @(posedge clk); #1 irq_clr = 1'b1;
    @(posedge clk); #1 irq_clr = 1'b0;
    @(negedge clk);
    check("irq_cleared", done_irq, 1'b0);
    irq_clr = 1'b1;
`endif

    send(20, 0, 4, 1);
    wait_drain("ramp_down");
    check("down_duty", pwm_duty, 0);
`ifdef PWM_RAMP_IRQ_EN
    check("irq_set_wins", done_irq, 1'b1);
    @(posedge clk); #1 irq_clr = 1'b0;
    @(negedge clk); #1;
    check("irq_clr_after", done_irq, 1'b0);
`endif

    send(20, 0, 5, 3);
    wait_drain("reload");
    check("reload_duty", pwm_duty, 0);

    send(8, 8, 2, 0);
    wait_drain("hold_zero");
    check("hold_zero_duty", pwm_duty, 8);
    check("hold_zero_period", pwm_period, 8);

    send(0, 31, 0, 0);
    wait_drain("clamp");
    check("clamp_period", pwm_period, 1);
    check("clamp_duty", pwm_duty, 1);

    base = en_seen;
    send(20, 20, 2, 1);
    budget = 0;
    while (en_seen < base + 2 && budget < 5000) begin
      @(negedge clk); #1;
      budget++;
    end
    check("stop_progress", en_seen - base, 2);
    stop       = 1'b1;
    cmd_valid  = 1'b1;
    cmd_period = W'(5);
    cmd_duty   = W'(5);
    cmd_step   = W'(1);
    cmd_hold   = HW'(1);
    #1;
    check("stop_ready", cmd_ready, 1'b0);
    sb.delete();
    sb.push_back('{20, 0, 0});
    cur_duty = 0;
    @(posedge clk); #1;
    stop      = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk); #1;
    check("stop_duty", pwm_duty, 0);
    check("stop_en", pwm_en, 1'b1);
    check("stop_busy", busy, 1'b0);
    check("stop_period", pwm_period, 20);
    repeat (150) @(negedge clk);
    #1;
    check("stop_idle_busy", busy, 1'b0);
    check("stop_idle_period", pwm_period, 20);
    check("stop_idle_queue", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
